// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch stage: fetches bytes at the PC over a req/ack port and queues them with their addresses.
// Optional PREFETCH_STATS_EN adds stat_discard, a saturating count of discarded bytes.
module instr_prefetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          pc_addr,
    input  logic                       flush,
    output logic                       pc_count_en,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic                       mem_ack,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       q_valid,
    output logic [DATA_W-1:0]          q_data,
    output logic [ADDR_W-1:0]          q_addr,
    input  logic                       q_ready,
    output logic [$clog2(DEPTH+1)-1:0] q_level
`ifdef PREFETCH_STATS_EN
    ,
    output logic [15:0]                stat_discard
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);
    localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, DRAIN} state_t;

    state_t                         state_q, state_d;
    logic                           mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]              mem_addr_q, mem_addr_d;
    logic [DEPTH-1:0][DATA_W-1:0]   data_q, data_d;
    logic [DEPTH-1:0][ADDR_W-1:0]   addr_q, addr_d;
    logic [PTR_W-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]               count_q, count_d;
    logic                           push, pop;

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        push       = 1'b0;
        case (state_q)
            IDLE: begin
                // Free-slot check uses the registered level; a same-cycle pop does not help.
                if (!flush && count_q < FULL) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc_addr;
                    state_d    = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                    push      = !flush;
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Only a kept byte advances the PC, so a jump is never masked.
    assign pc_count_en = push;

    always_comb begin
        pop      = (count_q != '0) && q_ready;
        data_d   = data_q;
        addr_d   = addr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                data_d[wr_ptr_q] = mem_rdata;
                addr_d[wr_ptr_q] = mem_addr_q;
                wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)
                count_d = count_q + LVL_W'(1);
            else if (pop && !push)
                count_d = count_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            data_q     <= '0;
            addr_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign q_valid  = (count_q != '0);
    assign q_data   = data_q[rd_ptr_q];
    assign q_addr   = addr_q[rd_ptr_q];
    assign q_level  = count_q;

`ifdef PREFETCH_STATS_EN
    logic [15:0] stat_q, stat_d;
    logic        ack_drop;
    logic [16:0] stat_sum;

    always_comb begin
        ack_drop = mem_ack && ((state_q == DRAIN) || (state_q == WAIT_ACK && flush));
        stat_sum = {1'b0, stat_q} + (flush ? 17'(count_q) : 17'd0) + 17'(ack_drop);
        stat_d   = stat_sum[16] ? 16'hFFFF : stat_sum[15:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stat_q <= '0;
        else      stat_q <= stat_d;
    end

    assign stat_discard = stat_q;
`endif

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a transaction-level queue model.
module tb_instr_prefetch_queue;

    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             rst;
    logic [15:0]      pc_addr;
    logic             flush;
    logic             pc_count_en;
    logic             mem_req;
    logic [15:0]      mem_addr;
    logic             mem_ack;
    logic [7:0]       mem_rdata;
    logic             q_valid;
    logic [7:0]       q_data;
    logic [15:0]      q_addr;
    logic             q_ready;
    logic [LVL_W-1:0] q_level;
`ifdef PREFETCH_STATS_EN
    logic [15:0]      stat_discard;
`endif

    instr_prefetch_queue #(.DEPTH(DEPTH), .ADDR_W(16), .DATA_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_addr     (pc_addr),
        .flush       (flush),
        .pc_count_en (pc_count_en),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .q_valid     (q_valid),
        .q_data      (q_data),
        .q_addr      (q_addr),
        .q_ready     (q_ready),
        .q_level     (q_level)
`ifdef PREFETCH_STATS_EN
        ,
        .stat_discard(stat_discard)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        logic [15:0] a;
    } ent_t;

    // Model: queued bytes, one outstanding request, and whether a jump has orphaned it.
    ent_t        mq[$];
    bit          m_open;
    bit          m_doomed;
    logic [15:0] m_req_addr;
    logic [15:0] pc_m;
    int          m_stat;

    int errors = 0;
    int checks = 0;
    int ce_cnt = 0;
    bit last_ce;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_open   = 0;
        m_doomed = 0;
        m_req_addr = '0;
        m_stat   = 0;
        pc_m     = 16'h0000;
    endtask

    // Called at a negedge; drives one cycle of inputs, checks, advances the model, returns at the next negedge.
    task automatic step(input bit f, input bit a, input logic [7:0] rd, input bit r, input logic [15:0] tgt);
        int  sz;
        bit  acc, psh, drop, iss, exp_ce;
        pc_addr   = pc_m;
        flush     = f;
        mem_ack   = a;
        mem_rdata = rd;
        q_ready   = r;
        #1;
        sz     = mq.size();
        acc    = m_open && a;
        psh    = acc && !m_doomed && !f;
        drop   = acc && (m_doomed || f);
        iss    = !m_open && !f && (sz < DEPTH);
        exp_ce = psh;
        chk("mem_req", mem_req, m_open);
        if (m_open) chk("mem_addr", mem_addr, m_req_addr);
        chk("q_valid", q_valid, sz != 0);
        chk("q_level", q_level, sz);
        if (sz != 0) begin
            chk("q_data", q_data, mq[0].d);
            chk("q_addr", q_addr, mq[0].a);
        end
        chk("pc_count_en", pc_count_en, exp_ce);
`ifdef PREFETCH_STATS_EN
        chk("stat_discard", stat_discard, m_stat);
`endif
        last_ce = pc_count_en;
        if (pc_count_en) ce_cnt++;
        m_stat = m_stat + (f ? sz : 0) + (drop ? 1 : 0);
        if (m_stat > 65535) m_stat = 65535;
        if (f) mq.delete();
        else begin
            if (sz > 0 && r) void'(mq.pop_front());
            if (psh) mq.push_back('{rd, m_req_addr});
        end
        if (acc) begin
            m_open   = 0;
            m_doomed = 0;
        end else if (m_open && f) begin
            m_doomed = 1;
        end
        if (iss) begin
            m_open     = 1;
            m_doomed   = 0;
            m_req_addr = pc_m;
        end
        if (f) pc_m = tgt;
        else if (psh) pc_m = pc_m + 16'd1;
        @(negedge clk);
    endtask

    // Asserts reset at a negedge, checks the cleared outputs, releases at the next negedge.
    task automatic do_reset();
        rst     = 1'b0;
        flush   = 1'b0;
        mem_ack = 1'b0;
        q_ready = 1'b0;
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_q_valid", q_valid, 0);
        chk("rst_q_level", q_level, 0);
        chk("rst_q_data", q_data, 0);
        chk("rst_q_addr", q_addr, 0);
        chk("rst_pc_count_en", pc_count_en, 0);
`ifdef PREFETCH_STATS_EN
        chk("rst_stat", stat_discard, 0);
`endif
        model_clear();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        q_ready   = 1'b0;
        pc_addr   = '0;
        @(negedge clk);
        do_reset();
        pc_m = 16'h0200;

        // Fill: ack every request as soon as it is visible, decoder stalled.
        repeat (12) step(0, m_open, 8'($urandom), 0, 16'h0);
        chk("t1_level", q_level, 4);
        chk("t1_req_idle", mem_req, 0);
        chk("t1_ce_pulses", ce_cnt, 4);
        chk("t1_head_addr", q_addr, 16'h0200);
        chk("t1_model_tail", mq[3].a, 16'h0203);

        // Pop one, then refill request at the next address.
        step(0, 0, 8'h00, 1, 16'h0);
        chk("t2_level", q_level, 3);
        chk("t2_head_addr", q_addr, 16'h0201);
        step(0, 0, 8'h00, 0, 16'h0);
        chk("t2_req", mem_req, 1);
        chk("t2_req_addr", mem_addr, 16'h0204);

        // Jump while waiting; ack arrives 3 cycles later and is dropped.
        step(1, 0, 8'h00, 0, 16'h8000);
        chk("t3_level", q_level, 0);
        chk("t3_req_held", mem_req, 1);
        step(0, 0, 8'h00, 0, 16'h0);
        step(0, 0, 8'h00, 0, 16'h0);
        step(0, 1, 8'hEE, 0, 16'h0);
        chk("t3_no_ce", last_ce, 0);
        chk("t3_level_after", q_level, 0);
`ifdef PREFETCH_STATS_EN
        chk("t6_stat", stat_discard, 4);
`endif
        step(0, 0, 8'h00, 0, 16'h0);
        chk("t3_new_req", mem_req, 1);
        chk("t3_new_addr", mem_addr, 16'h8000);

        // Jump coinciding with ack.
        step(1, 1, 8'h77, 0, 16'h9000);
        chk("t4_no_ce", last_ce, 0);
        chk("t4_level", q_level, 0);
        chk("t4_req_off", mem_req, 0);
        step(0, 0, 8'h00, 0, 16'h0);
        chk("t4_new_addr", mem_addr, 16'h9000);

        // Reset mid-request, then a stray ack.
        do_reset();
        step(0, 1, 8'h55, 0, 16'h0);
        chk("t5_level", q_level, 0);
        chk("t5_req", mem_req, 1);
        chk("t5_addr", mem_addr, 16'h0000);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 19) == 0,
                     m_open && ($urandom_range(0, 2) == 0),
                     8'($urandom),
                     $urandom_range(0, 1) == 1,
                     16'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
